// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way (2 or 4) set-associative, write-through, read-allocate cache with
// tree pseudo-LRU replacement, registered SRAM handshakes and saturating hit/miss counters.
module set_assoc_cache #(
   parameter int unsigned INDEX_W = 6,
   parameter int unsigned TAG_W   = 10,
   parameter int unsigned WAYS    = 2,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      address,
   input  logic [31:0]      writeData,
   input  logic             wrEn,
   input  logic             rdEn,
   output logic [31:0]      readData,
   output logic             ready,
   output logic [31:0]      sramAddress,
   output logic [31:0]      sramWriteData,
   output logic             sramWrEn,
   output logic             sramRdEn,
   input  logic [63:0]      sramReadData,
   input  logic             sramReady,
   output logic [CNT_W-1:0] hitCount,
   output logic [CNT_W-1:0] missCount
);
   localparam int unsigned Sets  = 2 ** INDEX_W;
   localparam int unsigned WayW  = (WAYS > 2) ? 2 : 1;
   localparam int unsigned PlruW = (WAYS > 2) ? 3 : 1;

   typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

   state_e           state_q;
   logic             sram_rd_q, sram_wr_q;
   logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

   logic [63:0]      data_q  [WAYS][Sets];
   logic [TAG_W-1:0] tag_q   [WAYS][Sets];
   logic [WAYS-1:0]  valid_q [Sets];
   logic [PlruW-1:0] plru_q  [Sets];

   logic               word_sel;
   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   tag;
   logic               hit;
   logic [WayW-1:0]    hit_way, victim, plru_victim, touch_way;
   logic               inv_found;
   logic [PlruW-1:0]   plru_cur, plru_touch;
   logic [63:0]        hit_line;
   logic               unused_addr;

   assign word_sel    = address[2];
   assign idx         = address[3 +: INDEX_W];
   assign tag         = address[3+INDEX_W +: TAG_W];
   assign unused_addr = ^{address[1:0], address[31:3+INDEX_W+TAG_W]};

   assign plru_cur = plru_q[idx];
   assign hit_line = data_q[hit_way][idx];

   // Tag compare; the lowest matching way wins if duplicates ever exist.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit && valid_q[idx][w] && (tag_q[w][idx] == tag)) begin
            hit     = 1'b1;
            hit_way = WayW'(w);
         end
      end
   end

   // Victim: lowest invalid way, otherwise the pseudo-LRU choice.
   always_comb begin
      victim    = plru_victim;
      inv_found = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!inv_found && !valid_q[idx][w]) begin
            inv_found = 1'b1;
            victim    = WayW'(w);
         end
      end
   end

   // A fill touches the victim; hits and write hits touch the hit way.
   assign touch_way = (state_q == StFill) ? victim : hit_way;

   if (WAYS > 2) begin : g_plru4
      assign plru_victim = plru_cur[0] ? {1'b1, plru_cur[2]} : {1'b0, plru_cur[1]};
      // Point every tree bit on the path away from the touched way.
      always_comb begin
         plru_touch    = plru_cur;
         plru_touch[0] = ~touch_way[1];
         if (touch_way[1]) plru_touch[2] = ~touch_way[0];
         else              plru_touch[1] = ~touch_way[0];
      end
   end else begin : g_plru2
      assign plru_victim = plru_cur[0];
      assign plru_touch  = ~touch_way;
   end

   // Control FSM with registered SRAM strobes, valid/PLRU state and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         sram_rd_q  <= 1'b0;
         sram_wr_q  <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         for (int s = 0; s < Sets; s++) begin
            valid_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (wrEn) begin
                  state_q   <= StWrite;
                  sram_wr_q <= 1'b1;
               end else if (rdEn) begin
                  if (hit) begin
                     plru_q[idx] <= plru_touch;
                     if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                  end else begin
                     state_q   <= StFill;
                     sram_rd_q <= 1'b1;
                  end
               end
            end
            StFill: begin
               if (sramReady) begin
                  valid_q[idx][victim] <= 1'b1;
                  plru_q[idx]          <= plru_touch;
                  if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                  state_q   <= StIdle;
                  sram_rd_q <= 1'b0;
               end
            end
            StWrite: begin
               if (sramReady) begin
                  if (hit) plru_q[idx] <= plru_touch;
                  state_q   <= StIdle;
                  sram_wr_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= StIdle;
               sram_rd_q <= 1'b0;
               sram_wr_q <= 1'b0;
            end
         endcase
      end
   end

   // Line data and tags: filled on miss completion, single word patched on write hit.
   always_ff @(posedge clk) begin
      if ((state_q == StFill) && sramReady) begin
         data_q[victim][idx] <= sramReadData;
         tag_q[victim][idx]  <= tag;
      end else if ((state_q == StWrite) && sramReady && hit) begin
         if (word_sel) data_q[hit_way][idx][63:32] <= writeData;
         else          data_q[hit_way][idx][31:0]  <= writeData;
      end
   end

   // Completion and load data: hits answer combinationally, misses from the SRAM line.
   always_comb begin
      ready    = 1'b1;
      readData = word_sel ? hit_line[63:32] : hit_line[31:0];
      unique case (state_q)
         StIdle:  ready = !(wrEn || (rdEn && !hit));
         StFill: begin
            ready    = sramReady;
            readData = word_sel ? sramReadData[63:32] : sramReadData[31:0];
         end
         StWrite: ready = sramReady;
         default: ready = 1'b1;
      endcase
   end

   assign sramAddress   = address;
   assign sramWriteData = writeData;
   assign sramRdEn      = sram_rd_q;
   assign sramWrEn      = sram_wr_q;
   assign hitCount      = hit_cnt_q;
   assign missCount     = miss_cnt_q;

endmodule
